// File: rtl/div_unit_pkg.sv
// div_unit_pkg: shared widths, state codes and handshake constants for the divider
package div_unit_pkg;
  localparam int REG_W = 32;
  localparam int DREG_W = 2 * REG_W;
  typedef enum logic [1:0] {
    DIV_FREE    = 2'b00,
    DIV_BY_ZERO = 2'b01,
    DIV_ON      = 2'b10,
    DIV_END     = 2'b11
  } div_state_e;
  localparam logic RESULT_READY = 1'b1;
  localparam logic RESULT_NOT_READY = 1'b0;
  localparam logic DIV_START = 1'b1;
  localparam logic DIV_STOP = 1'b0;
endpackage

// File: rtl/div_unit_step.sv
// div_step: one restoring-division iteration on the {partial remainder, dividend/quotient} register
module div_step #(
  parameter int DATA_W = 32
) (
  input  logic [2*DATA_W:0] w,
  input  logic [DATA_W-1:0] dsor,
  output logic [2*DATA_W:0] w_n
);
  logic [DATA_W+1:0] diff;
  logic neg;
  // trial subtract on the upper DATA_W+1 bits; keep the difference only if it did not borrow
  always_comb begin
    diff = {1'b0, w[2*DATA_W:DATA_W]} - {2'b0, dsor};
    neg = diff[DATA_W+1] | diff[DATA_W];
    w_n = neg ? {w[2*DATA_W-1:0], 1'b0} : {diff[DATA_W-1:0], w[DATA_W-1:0], 1'b1};
  end
endmodule

// File: rtl/div_unit.sv
// div_unit: multi-cycle radix-2 restoring DIV/DIVU; result_o = {remainder, quotient}; DIV_ANNUL_EN enables annul_i
module div_unit
  import div_unit_pkg::*;
#(
  parameter int DATA_W = REG_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic                  annul_i,
  input  logic                  signed_div_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o
);
  localparam int CW = $clog2(DATA_W);
  localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);
  div_state_e state, state_n;
  logic [2*DATA_W:0] w, w_n;
  logic [DATA_W-1:0] dsor, a_abs, d_abs, q, r;
  logic [2*DATA_W-1:0] res, result_n;
  logic [CW-1:0] cnt;
  logic neg_q, neg_r, ready_n, annul, accept;
`ifdef DIV_ANNUL_EN
  assign annul = annul_i;
`else
  assign annul = annul_i & 1'b0;
`endif
  assign accept = start_i == DIV_START && !annul;
  assign a_abs = signed_div_i && opdata1_i[DATA_W-1] ? -opdata1_i : opdata1_i;
  assign d_abs = signed_div_i && opdata2_i[DATA_W-1] ? -opdata2_i : opdata2_i;
  assign q = w_n[DATA_W-1:0];
  assign r = w_n[2*DATA_W:DATA_W+1];
  div_step #(.DATA_W(DATA_W)) u_step (.w(w), .dsor(dsor), .w_n(w_n));
  // state and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= DIV_FREE;
      ready_o <= RESULT_NOT_READY;
      result_o <= '0;
    end else begin
      state <= state_n;
      ready_o <= ready_n;
      result_o <= result_n;
    end
  end
  // next-state selection; annul aborts any busy state
  always_comb begin
    state_n = state;
    if (annul && state != DIV_FREE) state_n = DIV_FREE;
    else
      case (state)
        DIV_FREE:    if (accept) state_n = opdata2_i == '0 ? DIV_BY_ZERO : DIV_ON;
        DIV_BY_ZERO: state_n = DIV_END;
        DIV_ON:      if (cnt == LAST) state_n = DIV_END;
        DIV_END:     if (ready_o && start_i == DIV_STOP) state_n = DIV_FREE;
        default:     state_n = DIV_FREE;
      endcase
  end
  // ready rises on the first END cycle, holds while start is held, and the result is zero whenever not ready
  always_comb begin
    ready_n = state == DIV_END && !annul && (!ready_o || start_i == DIV_START) ? RESULT_READY : RESULT_NOT_READY;
    result_n = ready_n ? res : '0;
  end
  // operand capture, iteration and sign correction of the final step
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      w <= '0;
      res <= '0;
      dsor <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else
      case (state)
        DIV_FREE:
          if (accept && opdata2_i != '0) begin
            dsor <= d_abs;
            w <= {{DATA_W{1'b0}}, a_abs, 1'b0};
            neg_q <= signed_div_i & (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
            neg_r <= signed_div_i & opdata1_i[DATA_W-1];
            cnt <= '0;
          end
        DIV_BY_ZERO: begin
          w <= '0;
          res <= '0;
        end
        DIV_ON: begin
          w <= w_n;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) res <= {neg_r ? -r : r, neg_q ? -q : q};
        end
        default: ;
      endcase
  end
endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multi-cycle radix-2 restoring divider for DIV/DIVU in the EX stage.
- Its 64-bit result is the HI/LO write data: remainder goes to HI, quotient goes to LO.
- The result flows through MEM/WB to the HI/LO register write port.
- The EX stage holds start_i high and stalls the pipeline until ready_o is asserted.

Parameters:
- DATA_W, 32, operand width (matches RegBus); the iteration count equals DATA_W.

Ports:
- clk  in  1  clock
- rst  in  1  reset: synchronous, active-high
- start_i  in  1  divide request; held high by EX until ready_o is seen
- annul_i  in  1  flush/cancel of the in-flight divide (effective only with DIV_ANNUL_EN)
- signed_div_i  in  1  1 = DIV (signed), 0 = DIVU
- opdata1_i  in  DATA_W  dividend
- opdata2_i  in  DATA_W  divisor
- result_o  out  2*DATA_W  {remainder, quotient}; upper half feeds hi_i, lower half feeds lo_i
- ready_o  out  1  result valid

Behaviour:
- States: FREE, BY_ZERO, ON, END (2-bit encoding, constants in the package).
- Reset: the following take effect at the next rising edge with rst=1, from any state including mid-divide. No partial result is ever presented.
  - state <= FREE
  - ready_o <= 0
  - result_o <= 0
  - cnt <= 0
- FREE, start_i=1, divisor=0: go to BY_ZERO.
- FREE, start_i=1, divisor!=0 (edge E0):
  - Latch operands. When signed_div_i=1, convert negative operands to two's-complement magnitude.
  - Latch neg_q = sign1 XOR sign2 and neg_r = sign1 (signed only).
  - Load the working register {DATA_W'b0, |dividend|, 1'b0}; cnt <= 0; go to ON.
- ON, one step per edge:
  - Subtract |divisor| from the upper DATA_W+1 bits.
  - If the difference is non-negative, shift in the difference with LSB 1; otherwise shift the unchanged value with LSB 0.
  - cnt increments.
  - After DATA_W steps (edge E32): apply sign correction (negate quotient if neg_q, negate remainder if neg_r) and go to END.
- BY_ZERO: at the next edge, clear the working register to 0 and go to END. Divide-by-zero result is defined as 64'h0.
- END:
  - First edge in END (E33 for a normal divide): ready_o <= 1, result_o <= corrected value.
  - ready_o and result_o hold while start_i=1.
  - When start_i=0: at the next edge ready_o <= 0, result_o <= 0, state <= FREE.
- Latency: ready_o is high in the cycle after E33, i.e. 34 cycles after start_i is first sampled. Divide-by-zero: ready_o high after E2.
- start_i dropping during ON or BY_ZERO is ignored; the operation completes, and ready_o is high for exactly one cycle.
- Operand changes after E0 are ignored.
- Overflow: signed 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000, remainder 0 (wrap, no trap).
- A new start is accepted only in FREE. There is no back-to-back start without one cycle in FREE.

Optional Feature:
- Macro: DIV_ANNUL_EN.
- Defined:
  - annul_i=1 in ON, BY_ZERO or END forces at the next edge: state <= FREE, ready_o <= 0, result_o <= 0.
  - annul_i=1 in FREE blocks acceptance of start_i in that cycle.
- Undefined: annul_i is unconnected internally and has no effect; a divide always runs to completion.

Decomposition:
- Shared defines file (alongside RegBus/ZeroWord/RstEnable) holds:
  - DivFree / DivByZero / DivOn / DivEnd state codes
  - DivResultReady / DivResultNotReady
  - DivStart / DivStop
  - DoubleRegBus width
- One natural sub-module: div_step, a combinational single iteration (DATA_W+1 subtract and select), instantiated once inside the FSM.

Test Plan:
- Unsigned 100/7 (0x64/0x7), start held → ready_o rises at cycle 34; result_o = 0x00000002_0000000E.
- Signed -7/2 (0xFFFFFFF9/0x00000002) → result_o = 0xFFFFFFFF_FFFFFFFD.
- Divisor 0, dividend 0x12345678 → ready_o at cycle 2; result_o = 0; after start_i drops, ready_o = 0 one cycle later.
- Signed 0x80000000/0xFFFFFFFF → result_o = 0x00000000_80000000; unsigned 0xFFFFFFFF/0x10 → 0x0000000F_0FFFFFFF.
- rst=1 asserted at cycle 15 of a divide → next cycle state FREE, ready_o = 0, result_o = 0; a fresh 9/3 afterwards gives 0x00000000_00000003.
- DIV_ANNUL_EN: annul_i pulse at cycle 10 → FREE, ready_o never rises. Without the macro, the same stimulus completes normally.
